// File: rtl/sm3_byte_pack_if.sv
// Purpose: byte-stream intake and SM3 word-output handshake bundled for the byte packer.
// Latency: none, signal container only.
// Backpressure: byte side valid/ready, word side valid/ready; slave modport is the packer.
interface sm3_byte_pack_if #(
    parameter int CNT_W = 61
);
    logic [7:0]       byte_i;
    logic             byte_vld_i;
    logic             byte_lst_i;
    logic             byte_rdy_o;
    logic [31:0]      msg_inpt_d_o;
    logic [3:0]       msg_inpt_vld_byte_o;
    logic             msg_inpt_vld_o;
    logic             msg_inpt_lst_o;
    logic             msg_inpt_rdy_i;
    logic [CNT_W-1:0] msg_byte_cnt_o;
    logic             busy_o;

    // Environment side: feeds bytes and plays the SM3 core's ready.
    modport master (
        output byte_i, byte_vld_i, byte_lst_i, msg_inpt_rdy_i,
        input  byte_rdy_o, msg_inpt_d_o, msg_inpt_vld_byte_o, msg_inpt_vld_o,
        input  msg_inpt_lst_o, msg_byte_cnt_o, busy_o
    );

    // Packer side.
    modport slave (
        input  byte_i, byte_vld_i, byte_lst_i, msg_inpt_rdy_i,
        output byte_rdy_o, msg_inpt_d_o, msg_inpt_vld_byte_o, msg_inpt_vld_o,
        output msg_inpt_lst_o, msg_byte_cnt_o, busy_o
    );
endinterface

// File: rtl/sm3_byte_pack.sv
// Purpose: pack a byte-serial message big-endian into 32-bit words for the SM3 core.
// Latency: word visible on outputs one cycle after its final byte is accepted.
// Backpressure: a second completed word parks in the assembly register; byte_rdy_o drops (registered) until it moves out.
module sm3_byte_pack #(
    parameter int CNT_W = 61
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr_i,
    sm3_byte_pack_if.slave     bus
);
    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      asm_dat_q;
    logic [2:0]       asm_cnt_q;
    logic             asm_lst_q;
    logic [31:0]      out_dat_q;
    logic [3:0]       out_be_q;
    logic             out_vld_q;
    logic             out_lst_q;
    logic [CNT_W-1:0] cnt_q;
    logic             cnt_rst_q;

    logic             byte_acc;
    logic             out_fire;
    logic             word_done;
    logic             out_free;
    logic [31:0]      ins_dat;
    logic [2:0]       ins_cnt;

    // Byte count -> byte enables, filled from lane 3 downwards.
    function automatic logic [3:0] be_of(input logic [2:0] n);
        case (n)
            3'd1:    be_of = 4'b1000;
            3'd2:    be_of = 4'b1100;
            3'd3:    be_of = 4'b1110;
            default: be_of = 4'b1111;
        endcase
    endfunction

    assign byte_acc  = bus.byte_vld_i && (state_q == FILL);
    assign out_fire  = out_vld_q && bus.msg_inpt_rdy_i;
    assign ins_cnt   = asm_cnt_q + 3'd1;
    assign word_done = byte_acc && ((asm_cnt_q == 3'd3) || bus.byte_lst_i);
    assign out_free  = !out_vld_q || out_fire;

    // Place the incoming byte into the next free lane; lanes beyond it stay zero.
    always_comb begin
        ins_dat = asm_dat_q;
        case (asm_cnt_q[1:0])
            2'd0:    ins_dat[31:24] = bus.byte_i;
            2'd1:    ins_dat[23:16] = bus.byte_i;
            2'd2:    ins_dat[15:8]  = bus.byte_i;
            default: ins_dat[7:0]   = bus.byte_i;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     state_q <= FILL;
        else if (clr_i) state_q <= FILL;
        else            state_q <= state_d;
    end

    // FSM next state: park a completed word when the output register is busy.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL:    if (word_done && !out_free) state_d = HOLD;
            HOLD:    if (out_fire)               state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    // Assembly and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            asm_dat_q <= '0;
            asm_cnt_q <= '0;
            asm_lst_q <= 1'b0;
            out_dat_q <= '0;
            out_be_q  <= '0;
            out_vld_q <= 1'b0;
            out_lst_q <= 1'b0;
        end else if (clr_i) begin
            asm_dat_q <= '0;
            asm_cnt_q <= '0;
            asm_lst_q <= 1'b0;
            out_dat_q <= '0;
            out_be_q  <= '0;
            out_vld_q <= 1'b0;
            out_lst_q <= 1'b0;
        end else begin
            if (out_fire) out_vld_q <= 1'b0;
            if (state_q == HOLD) begin
                if (out_fire) begin
                    out_dat_q <= asm_dat_q;
                    out_be_q  <= be_of(asm_cnt_q);
                    out_lst_q <= asm_lst_q;
                    out_vld_q <= 1'b1;
                    asm_dat_q <= '0;
                    asm_cnt_q <= '0;
                    asm_lst_q <= 1'b0;
                end
            end else if (byte_acc) begin
                if (word_done && out_free) begin
                    out_dat_q <= ins_dat;
                    out_be_q  <= be_of(ins_cnt);
                    out_lst_q <= bus.byte_lst_i;
                    out_vld_q <= 1'b1;
                    asm_dat_q <= '0;
                    asm_cnt_q <= '0;
                    asm_lst_q <= 1'b0;
                end else begin
                    asm_dat_q <= ins_dat;
                    asm_cnt_q <= ins_cnt;
                    asm_lst_q <= bus.byte_lst_i;
                end
            end
        end
    end

    // Message byte counter; the lst byte is counted, then the count returns to zero one edge later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            cnt_rst_q <= 1'b0;
        end else if (clr_i) begin
            cnt_q     <= '0;
            cnt_rst_q <= 1'b0;
        end else if (byte_acc) begin
            cnt_q     <= (cnt_rst_q ? '0 : cnt_q) + CNT_W'(1);
            cnt_rst_q <= bus.byte_lst_i;
        end else begin
            cnt_q     <= cnt_rst_q ? '0 : cnt_q;
            cnt_rst_q <= 1'b0;
        end
    end

    assign bus.byte_rdy_o          = (state_q == FILL);
    assign bus.msg_inpt_d_o        = out_dat_q;
    assign bus.msg_inpt_vld_byte_o = out_be_q;
    assign bus.msg_inpt_vld_o      = out_vld_q;
    assign bus.msg_inpt_lst_o      = out_lst_q;
    assign bus.msg_byte_cnt_o      = cnt_q;
    assign bus.busy_o              = (asm_cnt_q != 3'd0) || (state_q == HOLD) || out_vld_q;
endmodule
